// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg: region map, region/state types and bank sizing helper shared by nn_mem_mgr.
package nn_mem_pkg;
  localparam logic [9:0] ND_BASE = 10'h000;
  localparam logic [9:0] WT_BASE = 10'h100;
  localparam logic [9:0] BS_BASE = 10'h200;
  typedef enum logic [1:0] {ND, WT, BS, INV} region_e;
  typedef logic state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RESP = 1'b1;
  function automatic int aw_of(input int d);
    return d > 1 ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/nn_mem_bank.sv
// nn_mem_bank: unreset register array with one synchronous write port and an asynchronous read port.
module nn_mem_bank
  import nn_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int AW = aw_of(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/nn_mem_mgr.sv
// nn_mem_mgr: request/response front end over neuron, weight and bias banks.
// Define NN_MEM_MGR_BURST_EN to enable multi-beat read bursts driven by req_len.
module nn_mem_mgr
  import nn_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int ND_DEPTH = 8,
  parameter int WT_DEPTH = 32,
  parameter int BS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_len,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              resp_last,
  output logic [7:0]        err_count
);
  localparam int HW = ADDR_W - 8;
  localparam int ND_AW = aw_of(ND_DEPTH);
  localparam int WT_AW = aw_of(WT_DEPTH);
  localparam int BS_AW = aw_of(BS_DEPTH);
  localparam logic [HW-1:0] ND_SEL = HW'(ND_BASE[9:8]);
  localparam logic [HW-1:0] WT_SEL = HW'(WT_BASE[9:8]);
  localparam logic [HW-1:0] BS_SEL = HW'(BS_BASE[9:8]);
  function automatic region_e rgn_of(input logic [HW-1:0] h);
    return h == ND_SEL ? ND : h == WT_SEL ? WT : h == BS_SEL ? BS : INV;
  endfunction
  function automatic logic ok_of(input region_e r, input logic [7:0] i);
    return r == ND ? int'(i) < ND_DEPTH : r == WT ? int'(i) < WT_DEPTH : r == BS ? int'(i) < BS_DEPTH : 1'b0;
  endfunction
  state_t state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic we_d, we_q;
  logic [7:0] err_d, err_q;
  logic [DATA_W-1:0] nd_rd, wt_rd, bs_rd, rd_mux;
  region_e req_rgn, cur_rgn;
  logic req_ok, cur_ok, accept, hs, wr_ok;
  assign req_rgn = rgn_of(req_addr[ADDR_W-1:8]);
  assign cur_rgn = rgn_of(addr_q[ADDR_W-1:8]);
  assign req_ok = ok_of(req_rgn, req_addr[7:0]);
  assign cur_ok = ok_of(cur_rgn, addr_q[7:0]);
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign accept = req_valid && req_ready;
  assign hs = resp_valid && resp_ready;
  assign wr_ok = accept && req_we && req_ok;
  nn_mem_bank #(.DATA_W(DATA_W), .DEPTH(ND_DEPTH)) u_nd (
    .clk(clk), .we_i(wr_ok && req_rgn == ND), .waddr_i(req_addr[ND_AW-1:0]),
    .wdata_i(req_wdata), .raddr_i(addr_q[ND_AW-1:0]), .rdata_o(nd_rd));
  nn_mem_bank #(.DATA_W(DATA_W), .DEPTH(WT_DEPTH)) u_wt (
    .clk(clk), .we_i(wr_ok && req_rgn == WT), .waddr_i(req_addr[WT_AW-1:0]),
    .wdata_i(req_wdata), .raddr_i(addr_q[WT_AW-1:0]), .rdata_o(wt_rd));
  nn_mem_bank #(.DATA_W(DATA_W), .DEPTH(BS_DEPTH)) u_bs (
    .clk(clk), .we_i(wr_ok && req_rgn == BS), .waddr_i(req_addr[BS_AW-1:0]),
    .wdata_i(req_wdata), .raddr_i(addr_q[BS_AW-1:0]), .rdata_o(bs_rd));
  assign rd_mux = cur_rgn == ND ? nd_rd : cur_rgn == WT ? wt_rd : bs_rd;
  assign resp_err = resp_valid && !cur_ok;
  assign resp_data = resp_valid && !we_q && cur_ok ? rd_mux : '0;
  assign err_count = err_q;
`ifdef NN_MEM_MGR_BURST_EN
  logic [7:0] cnt_d, cnt_q;
  assign resp_last = resp_valid && (we_q || !cur_ok || cnt_q == 8'd0);
  always_comb cnt_d = accept ? req_len : hs ? cnt_q - 8'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
`else
  logic unused_len;
  assign unused_len = ^req_len;
  assign resp_last = resp_valid;
`endif
  always_comb begin
    state_d = accept ? RESP : hs && resp_last ? IDLE : state_q;
    addr_d = accept ? req_addr : hs ? addr_q + ADDR_W'(1) : addr_q;
    we_d = accept ? req_we : we_q;
    err_d = hs && resp_err && err_q != 8'hFF ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      err_q <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      err_q <= err_d;
    end
endmodule
